// File: rtl/bf16_unit_arbiter_if.sv
// ---------------------------------------------------------------------------
// bf16_unit_arbiter_if
//   Bundles every signal between the arbiter and its surroundings: the two
//   requester channels, the two response channels, the operand/result bus of
//   the shared bf16 unit and the status outputs.
//
//   Handshake: a requester operation transfers on a rising clock edge where
//   reqN_valid and reqN_ready are both high. reqN_ready may depend
//   combinationally on reqN_valid; reqN_valid must never depend on
//   reqN_ready. Responses have no backpressure: rspN_valid is high for one
//   cycle and the requester must take rspN_result in that cycle.
//
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (requesters, bf16 unit, observers)
// ---------------------------------------------------------------------------
interface bf16_unit_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [15:0]      req0_in1;
    logic [15:0]      req0_in2;
    logic [15:0]      req0_in3;
    logic [4:0]       req0_funct5;
    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [15:0]      req1_in1;
    logic [15:0]      req1_in2;
    logic [15:0]      req1_in3;
    logic [4:0]       req1_funct5;
    // responses
    logic             rsp0_valid;
    logic [15:0]      rsp0_result;
    logic             rsp1_valid;
    logic [15:0]      rsp1_result;
    // shared bf16 unit
    logic [15:0]      u_in1;
    logic [15:0]      u_in2;
    logic [15:0]      u_in3;
    logic [4:0]       u_funct5;
    logic [15:0]      u_result;
    // status
    logic             busy;
    logic [CNT_W-1:0] issue_cnt;

    modport slave (
        input  req0_valid, req0_in1, req0_in2, req0_in3, req0_funct5,
        input  req1_valid, req1_in1, req1_in2, req1_in3, req1_funct5,
        input  u_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        output u_in1, u_in2, u_in3, u_funct5,
        output busy, issue_cnt
    );

    modport master (
        output req0_valid, req0_in1, req0_in2, req0_in3, req0_funct5,
        output req1_valid, req1_in1, req1_in2, req1_in3, req1_funct5,
        output u_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
        input  u_in1, u_in2, u_in3, u_funct5,
        input  busy, issue_cnt
    );
endinterface

// File: rtl/bf16_unit_arbiter.sv
// ---------------------------------------------------------------------------
// bf16_unit_arbiter
//   Shares one fixed-latency pipelined bf16 unit between two requesters.
//   Round-robin arbitration grants at most one requester per cycle; the
//   granted operands are registered onto u_in1/u_in2/u_in3/u_funct5. A tag
//   shift register of LATENCY+1 stages follows each operation through the
//   unit so u_result can be steered back to the requester that issued it.
//
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous, active-low reset
//     bus   - bf16_unit_arbiter_if.slave (requesters, responses, unit bus,
//             busy, issue_cnt)
//
//   Parameters:
//     LATENCY - edges from u_* operands presented to u_result valid (1..8)
//     CNT_W   - width of the accepted-operation counter
// ---------------------------------------------------------------------------
module bf16_unit_arbiter #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bf16_unit_arbiter_if.slave    bus
);

    // ---------------- state ----------------
    logic             rr_last_q,   rr_last_d;    // 1: requester 1 granted last
    logic [15:0]      u_in1_q,     u_in1_d;
    logic [15:0]      u_in2_q,     u_in2_d;
    logic [15:0]      u_in3_q,     u_in3_d;
    logic [4:0]       u_funct5_q,  u_funct5_d;
    logic [LATENCY:0] tag_v_q,     tag_v_d;      // stage k = op issued k edges ago
    logic [LATENCY:0] tag_id_q,    tag_id_d;     // requester id per stage
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [15:0]      rsp0_result_q, rsp0_result_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [15:0]      rsp1_result_q, rsp1_result_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

    // ---------------- arbitration ----------------
    logic gnt0;
    logic gnt1;
    logic hs;
    logic cap_v;
    logic cap_id;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            // tie: the requester that did not win last time gets the slot
            gnt0 = rr_last_q;
            gnt1 = ~rr_last_q;
        end else begin
            gnt0 = bus.req0_valid;
            gnt1 = bus.req1_valid;
        end
    end

    assign hs = gnt0 | gnt1;

    // The oldest tag stage describes the operation whose result is on
    // u_result right now; it is captured into the response registers.
    assign cap_v  = tag_v_q[LATENCY];
    assign cap_id = tag_id_q[LATENCY];

    // ---------------- next state ----------------
    always_comb begin
        rr_last_d     = rr_last_q;
        u_in1_d       = 16'h0000;
        u_in2_d       = 16'h0000;
        u_in3_d       = 16'h0000;
        u_funct5_d    = 5'd0;
        issue_cnt_d   = issue_cnt_q;
        tag_v_d       = {tag_v_q[LATENCY-1:0],  hs};
        tag_id_d      = {tag_id_q[LATENCY-1:0], gnt1};
        rsp0_valid_d  = cap_v & ~cap_id;
        rsp1_valid_d  = cap_v &  cap_id;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;

        if (gnt1) begin
            u_in1_d    = bus.req1_in1;
            u_in2_d    = bus.req1_in2;
            u_in3_d    = bus.req1_in3;
            u_funct5_d = bus.req1_funct5;
        end else if (gnt0) begin
            u_in1_d    = bus.req0_in1;
            u_in2_d    = bus.req0_in2;
            u_in3_d    = bus.req0_in3;
            u_funct5_d = bus.req0_funct5;
        end

        if (hs) begin
            rr_last_d   = gnt1;
            issue_cnt_d = issue_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (cap_v && !cap_id) begin
            rsp0_result_d = bus.u_result;
        end
        if (cap_v && cap_id) begin
            rsp1_result_d = bus.u_result;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_last_q     <= 1'b1;
            u_in1_q       <= 16'h0000;
            u_in2_q       <= 16'h0000;
            u_in3_q       <= 16'h0000;
            u_funct5_q    <= 5'd0;
            tag_v_q       <= '0;
            tag_id_q      <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= 16'h0000;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= 16'h0000;
            issue_cnt_q   <= '0;
        end else begin
            rr_last_q     <= rr_last_d;
            u_in1_q       <= u_in1_d;
            u_in2_q       <= u_in2_d;
            u_in3_q       <= u_in3_d;
            u_funct5_q    <= u_funct5_d;
            tag_v_q       <= tag_v_d;
            tag_id_q      <= tag_id_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            issue_cnt_q   <= issue_cnt_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.u_in1       = u_in1_q;
    assign bus.u_in2       = u_in2_q;
    assign bus.u_in3       = u_in3_q;
    assign bus.u_funct5    = u_funct5_q;
    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.busy        = |tag_v_q;
    assign bus.issue_cnt   = issue_cnt_q;

endmodule
